approx_adder_error_monitor: RTL
===============================

# approx_adder_error_monitor

Sequential error-characterisation stage that sits directly downstream of the 16-bit approximate adders. It consumes operand pairs together with the approximate adder's `WIDTH+1`-bit result and recomputes the exact sum internally. Over a programmable batch of samples it accumulates error count, sum of error distances and maximum error distance. Benches and on-chip characterisation harnesses use it to measure ER/MED/WCE without software post-processing.

## Interface
- `WIDTH`, 16, operand width; approximate result is `WIDTH+1` bits
- `CNT_WIDTH`, 16, width of batch-size and sample counters
- `clk_i`  in  1  single clock, rising edge
- `rst_i`  in  1  synchronous, active-high reset
- `start_i`  in  1  pulse; latches `num_samples_i`, clears statistics, begins a batch
- `num_samples_i`  in  CNT_WIDTH  batch size N
- `valid_i`  in  1  sample present on `add1_i`/`add2_i`/`approx_i`
- `ready_o`  out  1  block accepts a sample this cycle
- `add1_i`, `add2_i`  in  WIDTH  operands fed to the approximate adder
- `approx_i`  in  WIDTH+1  approximate adder result
- `busy_o`  out  1  batch in progress (RUN or DRAIN)
- `done_o`  out  1  statistics final and stable
- `err_count_o`  out  CNT_WIDTH  samples with nonzero error
- `err_sum_o`  out  WIDTH+1+CNT_WIDTH  sum of |approx − exact|
- `max_err_o`  out  WIDTH+1  largest |approx − exact|

## Operation
- FSM states: IDLE, RUN, DRAIN, DONE.
- IDLE/DONE + `start_i`: latch N, clear sample counter and all statistics, go to RUN. `start_i` is ignored in RUN/DRAIN.
- RUN: `ready_o` = 1 while accepted < N. A sample is accepted on `valid_i && ready_o`.
  - After the Nth acceptance, go to DRAIN.
  - N = 0 goes directly RUN→DRAIN with no acceptance; the result is all-zero statistics.
- Stage 1, registered on acceptance:
  - exact = `add1_i + add2_i`, WIDTH+1 bits, unsigned.
  - ed = |`approx_i` − exact|, WIDTH+1 bits, computed as a signed difference of width WIDTH+2, then magnitude.
  - Stage-1 valid bit is set.
- Stage 2, when stage-1 valid:
  - `err_sum` += ed.
  - `err_count` += (ed ≠ 0).
  - `max_err` = max(`max_err`, ed).
- Accumulator widths are sized so overflow is impossible for N ≤ 2^CNT_WIDTH − 1. No saturation logic.
- DRAIN: wait until the stage-1 valid bit is clear, then go to DONE.
- DONE: `done_o` = 1. Outputs hold until the next `start_i`.
- Outputs show running values during RUN/DRAIN. They are valid only while `done_o` = 1.
- Reset during any state: return to IDLE and flush the pipeline valid bit. The batch is discarded.

## Timing
- Reset values: `ready_o` 0, `busy_o` 0, `done_o` 0, `err_count_o` 0, `err_sum_o` 0, `max_err_o` 0.
- `start_i` sampled at edge s: RUN from edge s, so `ready_o` can be high in cycle s+1.
- Sample accepted at edge k: stage 1 loads at k, accumulators update at k+1.
- Last sample accepted at edge k: DRAIN from edge k, DONE (`done_o` high) from edge k+2.
- N = 0: DONE two edges after start.
- `ready_o` is a registered-state function only; it has no combinational path from `valid_i`.
- Throughput: one sample per cycle. Back-to-back `valid_i` with no bubbles is supported.
- `start_i` in the same cycle as `done_o` (DONE state): a new batch begins and statistics are cleared at that edge.

## Configuration
- `ERR_MONITOR_MSE_EN` defined:
  - Adds output `err_sq_sum_o` (2·(WIDTH+1)+CNT_WIDTH bits) accumulating ed² in stage 2, for MSE computation.
  - Cleared at start and on reset.
  - Latency is unchanged; the squarer sits in stage 2.
- Undefined: port and logic are absent, and there is no squarer.

## Test plan
- Reset mid-batch: `start_i` with N=4, accept 2 samples, assert `rst_i` → next cycle all outputs 0, state IDLE, `ready_o` 0.
- Exact batch: N=3, samples (3,1,4), (0xFFFF,0x0001,0x10000), (0,0,0) → `err_count_o`=0, `err_sum_o`=0, `max_err_o`=0, `done_o` two edges after the last accept.
- Error batch: N=3, samples (3,1,5), (0x0010,0x0010,0x001C), (0xFFFF,0xFFFF,0x1FFFE) → ed = 1, 4, 0; `err_count_o`=2, `err_sum_o`=5, `max_err_o`=4; with MSE enabled, `err_sq_sum_o`=17.
- Handshake: N=4, `valid_i` toggling 1,0,1,1,0,1 → exactly 4 accepts; `ready_o` drops after the 4th; further `valid_i` is ignored and statistics are unchanged.
- N=0 and restart: `start_i` with N=0 → `done_o` after 2 edges with zero stats. Then `start_i` with N=1 in DONE, one sample with ed=7 → `max_err_o`=7, `err_count_o`=1.
- `start_i` pulsed during RUN → ignored; N and counters are unchanged.

Source files
------------

// File: rtl/approx_adder_error_monitor.sv
`default_nettype none
// ============================================================================
// Module   : approx_adder_error_monitor
// Brief    : Batch error statistics (count, sum, max |approx - exact|) for an
//            approximate adder. Optional ed^2 accumulator: ERR_MONITOR_MSE_EN.
// Revision : 1.0 - initial release
// ============================================================================
module approx_adder_error_monitor #(
    parameter int WIDTH     = 16,
    parameter int CNT_WIDTH = 16
) (
    input  logic                          clk_i,
    input  logic                          rst_i,
    input  logic                          start_i,
    input  logic [CNT_WIDTH-1:0]          num_samples_i,
    input  logic                          valid_i,
    output logic                          ready_o,
    input  logic [WIDTH-1:0]              add1_i,
    input  logic [WIDTH-1:0]              add2_i,
    input  logic [WIDTH:0]                approx_i,
    output logic                          busy_o,
    output logic                          done_o,
    output logic [CNT_WIDTH-1:0]          err_count_o,
    output logic [WIDTH+CNT_WIDTH:0]      err_sum_o,
    output logic [WIDTH:0]                max_err_o
`ifdef ERR_MONITOR_MSE_EN
    ,
    output logic [2*(WIDTH+1)+CNT_WIDTH-1:0] err_sq_sum_o
`endif
);

    localparam logic [1:0]           c_idle    = 2'd0;
    localparam logic [1:0]           c_run     = 2'd1;
    localparam logic [1:0]           c_drain   = 2'd2;
    localparam logic [1:0]           c_done    = 2'd3;
    localparam logic [CNT_WIDTH-1:0] c_cnt_one = CNT_WIDTH'(1);

    logic [1:0]              r_state;
    logic [1:0]              w_state_next;
    logic [CNT_WIDTH-1:0]    r_num_samples;
    logic [CNT_WIDTH-1:0]    r_sample_cnt;
    logic                    r_s1_valid;
    logic [WIDTH:0]          r_ed;
    logic [CNT_WIDTH-1:0]    r_err_count;
    logic [WIDTH+CNT_WIDTH:0] r_err_sum;
    logic [WIDTH:0]          r_max_err;

    logic                    w_ready;
    logic                    w_accept;
    logic                    w_last;
    logic                    w_start;
    logic [WIDTH:0]          w_exact;
    logic [WIDTH+1:0]        w_diff;
    logic [WIDTH:0]          w_ed;

    assign w_ready  = (r_state == c_run) && (r_sample_cnt < r_num_samples);
    assign w_accept = valid_i && w_ready;
    assign w_last   = w_accept && (r_sample_cnt == (r_num_samples - c_cnt_one));
    assign w_start  = start_i && ((r_state == c_idle) || (r_state == c_done));

    // One extra bit of headroom makes the difference's sign bit exact.
    assign w_exact = {1'b0, add1_i} + {1'b0, add2_i};
    assign w_diff  = {1'b0, approx_i} - {1'b0, w_exact};
    assign w_ed    = w_diff[WIDTH+1] ? (WIDTH+1)'(-w_diff) : w_diff[WIDTH:0];

    always_comb begin
        w_state_next = r_state;
        case (r_state)
            c_idle:  if (start_i) w_state_next = c_run;
            c_run:   if (w_last || (r_sample_cnt == r_num_samples)) w_state_next = c_drain;
            c_drain: if (!r_s1_valid) w_state_next = c_done;
            c_done:  if (start_i) w_state_next = c_run;
            default: w_state_next = c_idle;
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            r_state <= c_idle;
        end else begin
            r_state <= w_state_next;
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            r_num_samples <= '0;
            r_sample_cnt  <= '0;
        end else if (w_start) begin
            r_num_samples <= num_samples_i;
            r_sample_cnt  <= '0;
        end else if (w_accept) begin
            r_sample_cnt  <= r_sample_cnt + c_cnt_one;
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            r_s1_valid <= 1'b0;
            r_ed       <= '0;
        end else begin
            r_s1_valid <= w_accept;
            if (w_accept) begin
                r_ed <= w_ed;
            end
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i || w_start) begin
            r_err_count <= '0;
            r_err_sum   <= '0;
            r_max_err   <= '0;
        end else if (r_s1_valid) begin
            r_err_count <= r_err_count + {{(CNT_WIDTH-1){1'b0}}, (r_ed != '0)};
            r_err_sum   <= r_err_sum + {{CNT_WIDTH{1'b0}}, r_ed};
            if (r_ed > r_max_err) begin
                r_max_err <= r_ed;
            end
        end
    end

`ifdef ERR_MONITOR_MSE_EN
    logic [2*(WIDTH+1)-1:0]              w_ed_sq;
    logic [2*(WIDTH+1)+CNT_WIDTH-1:0]    r_err_sq_sum;

    assign w_ed_sq = {{(WIDTH+1){1'b0}}, r_ed} * {{(WIDTH+1){1'b0}}, r_ed};

    always_ff @(posedge clk_i) begin
        if (rst_i || w_start) begin
            r_err_sq_sum <= '0;
        end else if (r_s1_valid) begin
            r_err_sq_sum <= r_err_sq_sum + {{CNT_WIDTH{1'b0}}, w_ed_sq};
        end
    end

    assign err_sq_sum_o = r_err_sq_sum;
`endif

    assign ready_o     = w_ready;
    assign busy_o      = (r_state == c_run) || (r_state == c_drain);
    assign done_o      = (r_state == c_done);
    assign err_count_o = r_err_count;
    assign err_sum_o   = r_err_sum;
    assign max_err_o   = r_max_err;

endmodule
`default_nettype wire
